// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO,
// with optional MADD/MADDU accumulate enabled by defining MDU_MADD_EN.
module e_mdu #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;

    // Decode of the incoming op: which ops start a multi-cycle run, and their latency.
    logic              is_long;
    logic [CNT_W-1:0]  lat_load;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        is_long  = 1'b0;
        lat_load = '0;
        case (op_e'(mdu_op))
            OP_MULT, OP_MULTU: begin
                is_long  = 1'b1;
                lat_load = CNT_W'(MULT_LAT);
            end
            OP_DIV, OP_DIVU: begin
                is_long  = 1'b1;
                lat_load = CNT_W'(DIV_LAT);
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                is_long  = 1'b1;
                lat_load = CNT_W'(MULT_LAT);
            end
`endif
            default: begin
                is_long  = 1'b0;
                lat_load = '0;
            end
        endcase
    end

    // Arithmetic on the registered operands; only sampled on the final RUN edge.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic        signed_div;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
        signed_div = (op_q == OP_DIV);
        mag_a      = (signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
        mag_b      = (signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;
        quo_mag    = (mag_b != 32'd0) ? (mag_a / mag_b) : 32'd0;
        rem_mag    = (mag_b != 32'd0) ? (mag_a % mag_b) : 32'd0;

        res_hi = HI;
        res_lo = LO;
        res_we = 1'b0;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_we           = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_we           = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // Division by zero leaves HI/LO untouched.
                res_we = (b_q != 32'd0);
                res_lo = (signed_div && (a_q[31] ^ b_q[31])) ? (~quo_mag + 32'd1) : quo_mag;
                res_hi = (signed_div && a_q[31]) ? (~rem_mag + 32'd1) : rem_mag;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                {res_hi, res_lo} = {HI, LO} + prod_s;
                res_we           = 1'b1;
            end
            OP_MADDU: begin
                {res_hi, res_lo} = {HI, LO} + prod_u;
                res_we           = 1'b1;
            end
`endif
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op_e'(mdu_op) == OP_MTHI) begin
                            HI <= A;
                        end else if (op_e'(mdu_op) == OP_MTLO) begin
                            LO <= A;
                        end else if (is_long) begin
                            op_q  <= op_e'(mdu_op);
                            a_q   <= A;
                            b_q   <= B;
                            cnt   <= lat_load;
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Starts arriving while busy are dropped here by construction.
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (res_we) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; MADD cases follow the MDU_MADD_EN build.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    e_mdu #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Present one op for a single edge; returns 1 ns after that edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = OP_NONE;
    endtask

    // Counts edges until busy falls, bounded so a stuck DUT still reaches the summary.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_released", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        mdu_op = OP_NONE;
        A      = '0;
        B      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // MULT -2 * 3, with HI/LO held during the run
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy_set", {63'd0, busy}, 64'd1);
        check("mult_hilo_held", {HI, LO}, 64'd0);
        wait_idle(cycles);
        check("mult_lat", 64'(cycles), 64'd5);
        check("mult_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);

        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_idle(cycles);
        check("multu_lat", 64'(cycles), 64'd5);
        check("multu_res", {HI, LO}, 64'h0000_0002_FFFF_FFFA);

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cycles);
        check("div_lat", 64'(cycles), 64'd10);
        check("div_res", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        // MTHI/MTLO then DIVU by zero
        issue(OP_MTHI, 32'h11, 32'd0);
        check("mthi_no_busy", {63'd0, busy}, 64'd0);
        check("mthi_hi", 64'(HI), 64'h11);
        issue(OP_MTLO, 32'h22, 32'd0);
        check("mtlo_lo", 64'(LO), 64'h22);
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle(cycles);
        check("divz_lat", 64'(cycles), 64'd10);
        check("divz_res", {HI, LO}, 64'h0000_0011_0000_0022);

        // Overflow case of signed divide
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cycles);
        check("div_ovf_res", {HI, LO}, 64'h0000_0000_8000_0000);

        // NOP and reserved codes change nothing
        issue(OP_NONE, 32'h1234, 32'h5678);
        check("nop_busy", {63'd0, busy}, 64'd0);
        issue(4'd12, 32'h1234, 32'h5678);
        check("rsvd_busy", {63'd0, busy}, 64'd0);
        check("rsvd_hilo", {HI, LO}, 64'h0000_0000_8000_0000);

        // MULTU during a DIV is ignored; MULTU in the cycle after busy falls is taken
        issue(OP_DIV, 32'd100, 32'd7);
        issue(OP_MULTU, 32'd3, 32'd4);
        check("ovl_busy", {63'd0, busy}, 64'd1);
        wait_idle(cycles);
        check("ovl_lat", 64'(cycles), 64'd9);
        check("ovl_res", {HI, LO}, 64'h0000_0002_0000_000E);
        issue(OP_MULTU, 32'd3, 32'd4);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_idle(cycles);
        check("b2b_lat", 64'(cycles), 64'd5);
        check("b2b_res", {HI, LO}, 64'h0000_0000_0000_000C);

        // Reset in cycle 3 of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = OP_MTHI;
        A      = 32'h55;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = OP_NONE;
        check("rst_no_accept", 64'(HI), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("rst_after_busy", {63'd0, busy}, 64'd0);
        check("rst_after_hilo", {HI, LO}, 64'd0);

        // MADDU accumulate, or NOP when the feature is absent
        issue(OP_MTHI, 32'd0, 32'd0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        check("maddu_busy", {63'd0, busy}, 64'd1);
        wait_idle(cycles);
        check("maddu_lat", 64'(cycles), 64'd5);
        check("maddu_res", {HI, LO}, 64'h0000_0001_0000_0000);
        issue(OP_MADD, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cycles);
        check("madd_res", {HI, LO}, 64'h0000_0000_FFFF_FFFE);
`else
        check("maddu_no_busy", {63'd0, busy}, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("maddu_busy_later", {63'd0, busy}, 64'd0);
        check("maddu_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
        issue(OP_MADD, 32'hFFFF_FFFF, 32'd2);
        check("madd_no_busy", {63'd0, busy}, 64'd0);
        check("madd_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL provide parameter MULT_LAT, default 5: cycles from the capture edge to the multiply/madd result edge.
REQ-002 SHALL provide parameter DIV_LAT, default 10: cycles from the capture edge to the divide result edge.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 SHALL have port mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; 9-15 reserved.
REQ-007 SHALL have port A  input  32  forwarded rs operand.
REQ-008 SHALL have port B  input  32  forwarded rt operand.
REQ-009 SHALL have port busy  output  1  operation in flight.
REQ-010 SHALL have port HI  output  32  architectural HI register, read by MFHI.
REQ-011 SHALL have port LO  output  32  architectural LO register, read by MFLO.

Function
REQ-012 SHALL accept an operation only at a rising edge where start=1, busy=0 and mdu_op is valid; otherwise it SHALL change no state.
REQ-013 SHALL treat start=1 while busy=1 as ignored, with no state change; the stall unit guarantees this never occurs architecturally.
REQ-014 SHALL treat mdu_op 0 and 9-15 as NOP.
REQ-015 SHALL, on accepting MTHI or MTLO, write A to HI or LO at that edge, with no busy assertion.
REQ-016 SHALL, on accepting MULT, MULTU, DIV, DIVU, MADD or MADDU, register the operands and op, load the down-counter with MULT_LAT or DIV_LAT, and set busy=1 from the next cycle.
REQ-017 SHALL use a two-state FSM: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on accept, RUN->IDLE when the counter reaches 1.
REQ-018 SHALL hold busy=1 for exactly LAT cycles, and SHALL update HI/LO at the same edge where busy falls.
REQ-019 SHALL keep HI/LO at their pre-operation values throughout RUN.
REQ-020 SHALL compute MULT as a signed 32x32->64 product and MULTU as unsigned; HI = bits 63:32, LO = bits 31:0.
REQ-021 SHALL compute DIV as signed with the quotient truncated toward zero into LO and the remainder, carrying the dividend's sign, into HI; DIVU as unsigned.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-023 SHALL, on division by zero, leave HI/LO unchanged while still running the full DIV_LAT busy period.
REQ-024 SHALL make HI/LO visible combinationally in the cycle after busy falls, and SHALL accept a new start in that same cycle.

Reset
REQ-025 SHALL, while reset=0, asynchronously force HI=0, LO=0, busy=0, counter=0 and FSM=IDLE.
REQ-026 SHALL, on reset asserted mid-RUN, discard the in-flight operation with no HI/LO update after release.
REQ-027 SHALL accept no start at an edge where reset=0.

Configuration
REQ-028 SHALL, with macro MDU_MADD_EN defined, implement MADD as {HI,LO} += signed A*B and MADDU as {HI,LO} += unsigned A*B, modulo 2^64, with MULT_LAT latency.
REQ-029 SHALL, without MDU_MADD_EN, treat mdu_op 7 and 8 as NOP, with no busy assertion and no HI/LO change.

Verification
REQ-030 SHALL cover: MULT A=0xFFFFFFFE, B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU on the same operands -> HI=0x2, LO=0xFFFFFFFA.
REQ-031 SHALL cover: DIV A=-7, B=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 after MTHI 0x11 and MTLO 0x22 -> HI=0x11, LO=0x22, busy high 10 cycles.
REQ-032 SHALL cover: start MULTU during the busy window of a DIV -> the second op is ignored and HI/LO reflect only the DIV; a MULTU started in the cycle busy falls is accepted.
REQ-033 SHALL cover: reset pulsed low at cycle 3 of a DIV -> HI=0, LO=0, busy=0 immediately, and they remain so after release.
REQ-034 SHALL cover, with MDU_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0; without MDU_MADD_EN: same stimulus -> HI=0, LO=0xFFFFFFFF, busy never set.
